// File: rtl/as_tap_imscan_pkg.sv
// Shared constants and the TAP state encoding for the IMSCAN JTAG responder.
package as_pack;

    localparam int im_scan_length = 43;

    localparam logic [7:0] IR_IMSCAN = 8'h80;
    localparam logic [7:0] IR_IDCODE = 8'h01;
    localparam logic [7:0] IR_BYPASS = 8'hFF;

    typedef enum logic [3:0] {
        TLR,
        RTI,
        SEL_DR,
        CAP_DR,
        SH_DR,
        EX1_DR,
        PAU_DR,
        EX2_DR,
        UPD_DR,
        SEL_IR,
        CAP_IR,
        SH_IR,
        EX1_IR,
        PAU_IR,
        EX2_IR,
        UPD_IR
    } tap_state_t;

endpackage

// File: rtl/as_tap_imscan_fsm.sv
// IEEE 1149.1 TAP controller: state register and next-state decode on TCK.
//
// state  | meaning
// TLR    | test-logic-reset, IR forced to BYPASS
// RTI    | run-test/idle
// SEL_DR | select DR scan
// CAP_DR | capture selected DR
// SH_DR  | shift selected DR
// EX1_DR | exit1 DR
// PAU_DR | pause DR, shift register held
// EX2_DR | exit2 DR
// UPD_DR | update DR
// SEL_IR | select IR scan
// CAP_IR | capture IR (8'b0000_0001)
// SH_IR  | shift IR
// EX1_IR | exit1 IR
// PAU_IR | pause IR
// EX2_IR | exit2 IR
// UPD_IR | update IR
module as_tap_fsm
    import as_pack::*;
(
    input  logic       tck_i,
    input  logic       trst_i,
    input  logic       tms_i,
    output logic [3:0] state_o
);

    tap_state_t state;
    tap_state_t state_nxt;

    always_ff @(posedge tck_i) begin
        if (!trst_i) begin
            state <= TLR;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            TLR:     state_nxt = tms_i ? TLR    : RTI;
            RTI:     state_nxt = tms_i ? SEL_DR : RTI;
            SEL_DR:  state_nxt = tms_i ? SEL_IR : CAP_DR;
            CAP_DR:  state_nxt = tms_i ? EX1_DR : SH_DR;
            SH_DR:   state_nxt = tms_i ? EX1_DR : SH_DR;
            EX1_DR:  state_nxt = tms_i ? UPD_DR : PAU_DR;
            PAU_DR:  state_nxt = tms_i ? EX2_DR : PAU_DR;
            EX2_DR:  state_nxt = tms_i ? UPD_DR : SH_DR;
            UPD_DR:  state_nxt = tms_i ? SEL_DR : RTI;
            SEL_IR:  state_nxt = tms_i ? TLR    : CAP_IR;
            CAP_IR:  state_nxt = tms_i ? EX1_IR : SH_IR;
            SH_IR:   state_nxt = tms_i ? EX1_IR : SH_IR;
            EX1_IR:  state_nxt = tms_i ? UPD_IR : PAU_IR;
            PAU_IR:  state_nxt = tms_i ? EX2_IR : PAU_IR;
            EX2_IR:  state_nxt = tms_i ? UPD_IR : SH_IR;
            UPD_IR:  state_nxt = tms_i ? SEL_DR : RTI;
            default: state_nxt = TLR;
        endcase
    end

    always_comb begin
        state_o = state;
    end

endmodule

// File: rtl/as_tap_imscan.sv
// JTAG responder giving a debug host write and readback access to I-Mem
// through a 43-bit {addr, data, we} scan register; everything runs on TCK.
module as_tap_imscan
    import as_pack::*;
#(
    parameter int          IR_WIDTH   = 8,
    parameter int          ADDR_WIDTH = 10,
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] IDCODE     = 32'h1000_0AB1
) (
    input  logic                  tck_i,
    input  logic                  trst_i,
    input  logic                  tms_i,
    input  logic                  tdi_i,
    output logic                  tdo_o,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    output logic [DATA_WIDTH-1:0] imem_data_o,
    output logic                  imem_we_o
);

    localparam int IM_LEN = ADDR_WIDTH + DATA_WIDTH + 1;

    logic [3:0]          state_bits;
    tap_state_t          state;
    logic [IR_WIDTH-1:0] ir;
    logic [IR_WIDTH-1:0] ir_sr;
    logic [IM_LEN-1:0]   im_sr;
    logic [31:0]         id_sr;
    logic                byp_sr;
    logic                sel_im;
    logic                sel_id;

    as_tap_fsm u_fsm (
        .tck_i   (tck_i),
        .trst_i  (trst_i),
        .tms_i   (tms_i),
        .state_o (state_bits)
    );

    assign state  = tap_state_t'(state_bits);
    assign sel_im = (ir == IR_WIDTH'(IR_IMSCAN));
    assign sel_id = (ir == IR_WIDTH'(IR_IDCODE));

    // Unknown instruction codes fall through to the 1-bit bypass register.
    always_ff @(posedge tck_i) begin
        if (!trst_i) begin
            ir          <= '1;
            ir_sr       <= '0;
            im_sr       <= '0;
            id_sr       <= '0;
            byp_sr      <= 1'b0;
            imem_addr_o <= '0;
            imem_data_o <= '0;
            imem_we_o   <= 1'b0;
        end else begin
            imem_we_o <= 1'b0;
            case (state)
                TLR:    ir    <= '1;
                CAP_IR: ir_sr <= IR_WIDTH'(1);
                SH_IR:  ir_sr <= {ir_sr[IR_WIDTH-2:0], tdi_i};
                UPD_IR: ir    <= ir_sr;
                CAP_DR: begin
                    if (sel_im)      im_sr  <= {imem_addr_o, imem_rdata_i, 1'b0};
                    else if (sel_id) id_sr  <= IDCODE;
                    else             byp_sr <= 1'b0;
                end
                SH_DR: begin
                    if (sel_im)      im_sr  <= {im_sr[IM_LEN-2:0], tdi_i};
                    else if (sel_id) id_sr  <= {id_sr[30:0], tdi_i};
                    else             byp_sr <= tdi_i;
                end
                UPD_DR: begin
                    if (sel_im) begin
                        imem_addr_o <= im_sr[IM_LEN-1 -: ADDR_WIDTH];
                        imem_data_o <= im_sr[DATA_WIDTH:1];
                        imem_we_o   <= im_sr[0];
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        tdo_o = 1'b0;
        if (state == SH_IR) begin
            tdo_o = ir_sr[IR_WIDTH-1];
        end else if (state == SH_DR) begin
            if (sel_im)      tdo_o = im_sr[IM_LEN-1];
            else if (sel_id) tdo_o = id_sr[31];
            else             tdo_o = byp_sr;
        end
    end

endmodule

// File: tb/tb_as_tap_imscan.sv
// Directed bench for as_tap_imscan: IR load, IM write/readback, IDCODE, bypass, pause, reset.
module tb_as_tap_imscan;

    logic        tck   = 1'b0;
    logic        trst  = 1'b0;
    logic        tms   = 1'b1;
    logic        tdi   = 1'b0;
    logic        tdo;
    logic [31:0] rdata = 32'h1234_5678;
    logic [9:0]  addr;
    logic [31:0] data;
    logic        we;

    int checks   = 0;
    int failures = 0;

    always #5 tck = ~tck;

    as_tap_imscan dut (
        .tck_i        (tck),
        .trst_i       (trst),
        .tms_i        (tms),
        .tdi_i        (tdi),
        .tdo_o        (tdo),
        .imem_rdata_i (rdata),
        .imem_addr_o  (addr),
        .imem_data_o  (data),
        .imem_we_o    (we)
    );

    task automatic step(input logic t, input logic d, output logic o);
        @(negedge tck);
        tms = t;
        tdi = d;
        #1 o = tdo;
        @(posedge tck);
        #1;
    endtask

    task automatic load_ir(input logic [7:0] code, output logic [7:0] cap);
        logic o;
        step(1, 0, o);
        step(1, 0, o);
        step(0, 0, o);
        step(0, 0, o);
        cap = '0;
        for (int i = 0; i < 8; i++) begin
            step(i == 7, code[7-i], o);
            cap = {cap[6:0], o};
        end
        step(1, 0, o);
        step(0, 0, o);
    endtask

    task automatic enter_shdr();
        logic o;
        step(1, 0, o);
        step(0, 0, o);
        step(0, 0, o);
    endtask

    task automatic shift_bits(input int n, input logic [63:0] din, input bit exit_last,
                              output logic [63:0] dout);
        logic o;
        dout = '0;
        for (int i = 0; i < n; i++) begin
            step(exit_last && (i == n - 1), din[n-1-i], o);
            dout = {dout[62:0], o};
        end
    endtask

    task automatic bypass_scan(output logic [3:0] res);
        logic [63:0] dout;
        logic        o;
        enter_shdr();
        shift_bits(4, 64'hD, 1, dout);
        step(1, 0, o);
        step(0, 0, o);
        res = dout[3:0];
    endtask

    task automatic test_reset();
        logic       o;
        logic [3:0] b;
        trst = 1'b0;
        repeat (2) begin
            @(negedge tck);
            tms = ~tms;
            tdi = ~tdi;
        end
        @(posedge tck);
        #1;
        checks++;
        if ({addr, data, we} !== 43'h0) begin
            failures++;
            $display("FAIL reset_outputs: got addr=%h data=%h we=%b, want 0/0/0", addr, data, we);
        end
        checks++;
        if (tdo !== 1'b0) begin
            failures++;
            $display("FAIL reset_tdo: got %b want 0", tdo);
        end
        @(negedge tck);
        trst = 1'b1;
        repeat (5) step(1, 0, o);
        step(0, 0, o);
        bypass_scan(b);
        checks++;
        if (b !== 4'b0110) begin
            failures++;
            $display("FAIL reset_ir_bypass: got %b want 0110", b);
        end
        checks++;
        if ({addr, data, we} !== 43'h0) begin
            failures++;
            $display("FAIL reset_bypass_upd: got addr=%h data=%h we=%b, want 0/0/0", addr, data, we);
        end
    endtask

    task automatic test_write();
        logic [7:0]  cap;
        logic [63:0] dout;
        logic [42:0] v;
        logic        o;
        v = {10'h004, 32'h0010_0093, 1'b1};
        rdata = 32'h1234_5678;
        load_ir(8'h80, cap);
        checks++;
        if (cap !== 8'h01) begin
            failures++;
            $display("FAIL ir_capture: got %h want 01", cap);
        end
        enter_shdr();
        shift_bits(43, {21'b0, v}, 1, dout);
        checks++;
        if (dout[42:0] !== {10'h000, 32'h1234_5678, 1'b0}) begin
            failures++;
            $display("FAIL write_capture: got %h want %h", dout[42:0], {10'h000, 32'h1234_5678, 1'b0});
        end
        checks++;
        if (we !== 1'b0) begin
            failures++;
            $display("FAIL write_we_ex1: got %b want 0", we);
        end
        step(1, 0, o);
        checks++;
        if (we !== 1'b0) begin
            failures++;
            $display("FAIL write_we_upd: got %b want 0", we);
        end
        step(0, 0, o);
        checks++;
        if ({addr, data, we} !== {10'h004, 32'h0010_0093, 1'b1}) begin
            failures++;
            $display("FAIL write_strobe: got addr=%h data=%h we=%b, want 004/00100093/1", addr, data, we);
        end
        step(0, 0, o);
        checks++;
        if (we !== 1'b0) begin
            failures++;
            $display("FAIL write_pulse_width: got %b want 0", we);
        end
    endtask

    task automatic test_no_write();
        logic [63:0] dout;
        logic        o;
        enter_shdr();
        shift_bits(43, {21'b0, 10'h000, 32'h4AAA_AA88, 1'b0}, 1, dout);
        checks++;
        if (dout[42:0] !== {10'h004, 32'h1234_5678, 1'b0}) begin
            failures++;
            $display("FAIL nowrite_capture: got %h want %h", dout[42:0], {10'h004, 32'h1234_5678, 1'b0});
        end
        step(1, 0, o);
        step(0, 0, o);
        checks++;
        if ({addr, data, we} !== {10'h000, 32'h4AAA_AA88, 1'b0}) begin
            failures++;
            $display("FAIL nowrite_update: got addr=%h data=%h we=%b, want 000/4aaaaa88/0", addr, data, we);
        end
        step(0, 0, o);
        checks++;
        if (we !== 1'b0) begin
            failures++;
            $display("FAIL nowrite_we: got %b want 0", we);
        end
    endtask

    task automatic test_readback();
        logic [63:0] dout;
        logic        o;
        enter_shdr();
        shift_bits(43, {21'b0, 10'h010, 32'h0, 1'b0}, 1, dout);
        step(1, 0, o);
        step(0, 0, o);
        rdata = 32'hDEAD_BEEF;
        enter_shdr();
        shift_bits(43, {21'b0, 10'h010, 32'h0, 1'b0}, 1, dout);
        checks++;
        if (dout[42:0] !== {10'h010, 32'hDEAD_BEEF, 1'b0}) begin
            failures++;
            $display("FAIL readback_tdo: got %h want %h", dout[42:0], {10'h010, 32'hDEAD_BEEF, 1'b0});
        end
        step(1, 0, o);
        step(0, 0, o);
        checks++;
        if ({addr, data, we} !== {10'h010, 32'h0, 1'b0}) begin
            failures++;
            $display("FAIL readback_update: got addr=%h data=%h we=%b, want 010/0/0", addr, data, we);
        end
    endtask

    task automatic test_idcode_bypass();
        logic [7:0]  cap;
        logic [63:0] dout;
        logic        o;
        load_ir(8'h01, cap);
        enter_shdr();
        shift_bits(32, 64'hA5A5_0F0F, 1, dout);
        checks++;
        if (dout[31:0] !== 32'h1000_0AB1) begin
            failures++;
            $display("FAIL idcode_tdo: got %h want 10000ab1", dout[31:0]);
        end
        step(1, 0, o);
        step(0, 0, o);
        checks++;
        if ({addr, data, we} !== {10'h010, 32'h0, 1'b0}) begin
            failures++;
            $display("FAIL idcode_upd: got addr=%h data=%h we=%b, want 010/0/0", addr, data, we);
        end
        load_ir(8'h3C, cap);
        enter_shdr();
        shift_bits(8, 64'hB2, 1, dout);
        checks++;
        if (dout[7:0] !== 8'b0101_1001) begin
            failures++;
            $display("FAIL bypass_tdo: got %b want 01011001", dout[7:0]);
        end
        step(1, 0, o);
        step(0, 0, o);
        checks++;
        if ({addr, data, we} !== {10'h010, 32'h0, 1'b0}) begin
            failures++;
            $display("FAIL bypass_upd: got addr=%h data=%h we=%b, want 010/0/0", addr, data, we);
        end
    endtask

    task automatic test_pause();
        logic [7:0]  cap;
        logic [63:0] dout;
        logic [42:0] v;
        logic        o;
        v = {10'h3A5, 32'hCAFE_F00D, 1'b1};
        load_ir(8'h80, cap);
        enter_shdr();
        shift_bits(20, {44'b0, v[42:23]}, 1, dout);
        step(0, 0, o);
        step(0, 1, o);
        step(0, 1, o);
        checks++;
        if (we !== 1'b0) begin
            failures++;
            $display("FAIL pause_we: got %b want 0", we);
        end
        step(1, 1, o);
        step(0, 0, o);
        shift_bits(23, {41'b0, v[22:0]}, 1, dout);
        step(1, 0, o);
        step(0, 0, o);
        checks++;
        if ({addr, data, we} !== {10'h3A5, 32'hCAFE_F00D, 1'b1}) begin
            failures++;
            $display("FAIL pause_write: got addr=%h data=%h we=%b, want 3a5/cafef00d/1", addr, data, we);
        end
        step(0, 0, o);
        checks++;
        if (we !== 1'b0) begin
            failures++;
            $display("FAIL pause_pulse_width: got %b want 0", we);
        end
    endtask

    task automatic test_reset_mid_shift();
        logic [63:0] dout;
        logic [3:0]  b;
        logic        o;
        bit          seen_we;
        enter_shdr();
        shift_bits(20, 64'hFFFFF, 0, dout);
        @(negedge tck);
        trst = 1'b0;
        tms  = 1'b1;
        tdi  = 1'b1;
        @(posedge tck);
        #1;
        checks++;
        if ({addr, data, we} !== 43'h0) begin
            failures++;
            $display("FAIL midreset_outputs: got addr=%h data=%h we=%b, want 0/0/0", addr, data, we);
        end
        @(negedge tck);
        trst = 1'b1;
        seen_we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(i == 3 ? 1'b0 : 1'b1, 1, o);
            if (we) seen_we = 1'b1;
        end
        checks++;
        if (seen_we !== 1'b0) begin
            failures++;
            $display("FAIL midreset_no_we: got %b want 0", seen_we);
        end
        bypass_scan(b);
        checks++;
        if (b !== 4'b0110) begin
            failures++;
            $display("FAIL midreset_ir_bypass: got %b want 0110", b);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_no_write();
        test_readback();
        test_idcode_bypass();
        test_pause();
        test_reset_mid_shift();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/as_tap_imscan.md
# as_tap_imscan

JTAG TAP responder that lets a debug host write and read back the instruction memory through a scan data register. It runs entirely on TCK, decodes the IEEE 1149.1 TAP state machine and an 8-bit instruction register, and turns a completed IMSCAN Update-DR into a single-cycle I-Mem write strobe. It sits between the chip JTAG pins and the I-Mem write port of `as_top_mem`. The CPU is held in reset while this port is in use, so CDC to `clk_i` is out of scope.

## Interface
- `IR_WIDTH`, 8, instruction register width
- `ADDR_WIDTH`, 10, I-Mem byte address width (`imem_addr_width`)
- `DATA_WIDTH`, 32, instruction width (`instr_width`)
- `IDCODE`, 32'h1000_0AB1, value captured by the IDCODE instruction; bit 0 must be 1
- `tck_i  in  1  JTAG clock; the only clock of the block`
- `trst_i  in  1  reset, synchronous, active-low`
- `tms_i  in  1  TAP mode select, sampled on rising tck_i`
- `tdi_i  in  1  serial data in, sampled on rising tck_i`
- `tdo_o  out  1  serial data out, combinational`
- `imem_rdata_i  in  DATA_WIDTH  I-Mem read data at imem_addr_o`
- `imem_addr_o  out  ADDR_WIDTH  I-Mem address, registered`
- `imem_data_o  out  DATA_WIDTH  I-Mem write data, registered`
- `imem_we_o  out  1  I-Mem write strobe, one-cycle pulse`

## Operation
- **TAP FSM.** Standard 16 states: TLR, RTI, SelDR, CapDR, ShDR, Ex1DR, PauDR, Ex2DR, UpdDR, and the IR equivalents. Transitions follow 1149.1 on every rising `tck_i`. Five consecutive `tms_i`=1 reach TLR from any state.
- **Instructions.**
  - 8'h80 IMSCAN: selects the IM data register.
  - 8'h01 IDCODE: 32-bit register.
  - 8'hFF BYPASS: 1-bit register.
  - Any other code selects BYPASS.
- **Shift order.** All registers shift MSB-first. Each ShIR/ShDR edge does `sr <= {sr[N-2:0], tdi_i}`, so the first bit shifted ends at the MSB.
- **`tdo_o`.**
  - In ShIR: the MSB of the IR shift register.
  - In ShDR: the MSB of the selected DR.
  - Otherwise 0.
- **IR path.**
  - CapIR loads 8'b0000_0001.
  - UpdIR copies the IR shift register to the IR.
  - TLR, or `trst_i`=0, sets IR to 8'hFF.
- **IM data register.** Width `IM_LEN` = ADDR_WIDTH + DATA_WIDTH + 1 = 43, laid out as {addr, data, we}, we = bit 0.
  - CapDR loads {imem_addr_o, imem_rdata_i, 1'b0}. This is the readback path.
  - UpdDR loads `imem_addr_o` and `imem_data_o` from the addr and data fields, and loads `imem_we_o` from the we bit.
- **IDCODE register.** CapDR loads `IDCODE`. UpdDR has no effect.
- **BYPASS register.** CapDR loads 0.
- **Pause.** PauDR and Ex2DR hold the shift register unchanged. Resuming via Ex2DR→ShDR continues the same shift.

## Timing
- **Reset.** `trst_i`=0 at a rising edge forces:
  - state = TLR, IR = 8'hFF;
  - all shift registers to 0;
  - `imem_addr_o` = 0, `imem_data_o` = 0, `imem_we_o` = 0.
  - Reset wins over any simultaneous TMS/TDI activity. A shift interrupted by reset is discarded with no write.
- **Write strobe.** `imem_we_o` rises on the edge that leaves UpdDR with IR = IMSCAN and we = 1. It is high for exactly one `tck_i` cycle and cleared on the next edge.
- **Write latency.** Last data bit (Ex1DR entry) + 2 edges gives the `imem_we_o` pulse.
- **No-write update.** UpdDR with we = 0 still updates addr and data, with no pulse. This supports setting a readback address.
- **Other instructions.** UpdDR under IDCODE or BYPASS leaves all `imem_*` outputs unchanged.
- **Exit without update.** Reaching TLR without passing UpdDR leaves the `imem_*` outputs unchanged.
- **IR during a DR scan.** The IR is stable during DR scans; it changes only in UpdIR, TLR, or reset.
- **Readback source.** `imem_rdata_i` must be valid combinationally or registered within one `tck_i` of an address change. CapDR samples it.

## Structure
- `as_pack` holds:
  - `im_scan_length` (43);
  - instruction constants `IR_IMSCAN` = 8'h80, `IR_IDCODE` = 8'h01, `IR_BYPASS` = 8'hFF;
  - `tap_state_t`, an enum of the 16 states.
- Sub-module `as_tap_fsm` contains only the TAP state register and next-state logic. It takes `tck_i`, `trst_i` and `tms_i` and outputs the state.
- `as_tap_imscan` contains the IR, the three data registers, the TDO mux and the I-Mem outputs.

## Test plan
1. **Reset.** `trst_i`=0 for 2 cycles, then tms=1 ×5 → state TLR, IR = 8'hFF, `imem_we_o` = 0, addr = 0, data = 0.
2. **Load IR and write.** Load IR 8'h80, then shift {10'h004, 32'h0010_0093, 1'b1} MSB-first and pass through UpdDR.
   - Expect `imem_addr_o` = 10'h004 and `imem_data_o` = 32'h0010_0093.
   - Expect `imem_we_o` high for exactly 1 cycle, 2 edges after Ex1DR.
3. **No-write update.** Shift {10'h000, 32'h4AAA_AA88, 1'b0} → addr and data update, `imem_we_o` stays 0.
4. **Readback.** With `imem_rdata_i` = 32'hDEAD_BEEF and addr = 10'h010:
   - CapDR followed by 43 ShDR edges → TDO emits 10'h010, then 32'hDEAD_BEEF, then 0, MSB-first.
5. **IDCODE and BYPASS.**
   - IR 8'h01, CapDR, 32 shifts → TDO emits `IDCODE` MSB-first.
   - IR 8'h3C → 1-bit bypass: TDO equals TDI delayed one cycle, first bit 0.
6. **Interrupted shift.** Pause mid-shift (PauDR ×3, then resume) → a write occurs with the correct 43-bit value. Assert `trst_i`=0 mid-ShDR → no `imem_we_o`, outputs return to 0.
